// File: rtl/mdu.sv
// Iterative multiply/divide unit: one bit per cycle, fixed 33-cycle latency,
// unsigned and two's-complement multiply and divide with MIPS-style Hi/Lo results.
module mdu #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [DATA_WIDTH-1:0] busA,
  input  logic [DATA_WIDTH-1:0] busB,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Hi,
  output logic [DATA_WIDTH-1:0] Lo
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     acc_hi_q, acc_hi_d;   // partial product high / partial remainder
  logic [W-1:0]     acc_lo_q, acc_lo_d;   // multiplier bits / dividend-quotient bits
  logic [W-1:0]     opb_q, opb_d;         // |multiplicand| or |divisor|
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;         // negate product / quotient
  logic             rneg_q, rneg_d;       // negate remainder (dividend sign)
  logic             div0_q, div0_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;

  // Operand conditioning at the start edge
  logic         sa_c, sb_c;
  logic [W-1:0] abs_a_c, abs_b_c;
  // Per-iteration datapath
  logic [W:0]   mul_sum_c;
  logic [W:0]   rem_sh_c;
  logic [W:0]   diff_c;
  // Sign-corrected results
  logic [2*W-1:0] prod_c;
  logic [W-1:0]   quo_c, rem_c;

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

  // State register
  always_ff @(posedge Clock) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: IDLE -> CALC (32 iterations) -> FIX -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitude and sign extraction for signed ops
  always_comb begin
    sa_c    = Op[0] & busA[W-1];
    sb_c    = Op[0] & busB[W-1];
    abs_a_c = sa_c ? (~busA + W'(1)) : busA;
    abs_b_c = sb_c ? (~busB + W'(1)) : busB;
  end

  // One shift-add / restoring shift-subtract step, plus final sign correction
  always_comb begin
    mul_sum_c = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    rem_sh_c  = {acc_hi_q, acc_lo_q[W-1]};
    diff_c    = rem_sh_c - {1'b0, opb_q};
    prod_c    = neg_q ? (~{acc_hi_q, acc_lo_q} + (2*W)'(1)) : {acc_hi_q, acc_lo_q};
    quo_c     = neg_q ? (~acc_lo_q + W'(1)) : acc_lo_q;
    rem_c     = rneg_q ? (~acc_hi_q + W'(1)) : acc_hi_q;
    if (div0_q) quo_c = '1;
  end

  // Next values for datapath and registered outputs
  always_comb begin
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          busy_d   = 1'b1;
          cnt_d    = '0;
          is_div_d = Op[1];
          neg_d    = sa_c ^ sb_c;
          rneg_d   = sa_c;
          div0_d   = Op[1] & (busB == '0);
          acc_hi_d = '0;
          // Multiply keeps the multiplier in the low half; divide keeps the dividend there
          acc_lo_d = Op[1] ? abs_a_c : abs_b_c;
          opb_d    = Op[1] ? abs_b_c : abs_a_c;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          if (!diff_c[W]) begin
            acc_hi_d = diff_c[W-1:0];
            acc_lo_d = {acc_lo_q[W-2:0], 1'b1};
          end else begin
            acc_hi_d = rem_sh_c[W-1:0];
            acc_lo_d = {acc_lo_q[W-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum_c[W:1];
          acc_lo_d = {mul_sum_c[0], acc_lo_q[W-1:1]};
        end
      end
      FIX: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (is_div_q) begin
          hi_d = rem_c;
          lo_d = quo_c;
        end else begin
          hi_d = prod_c[2*W-1:W];
          lo_d = prod_c[W-1:0];
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for the iterative multiply/divide unit.
module tb_mdu;

  logic        Clock;
  logic        Resetn;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] busA;
  logic [31:0] busB;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  mdu #(.DATA_WIDTH(32)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Start  (Start),
    .Op     (Op),
    .busA   (busA),
    .busB   (busB),
    .Busy   (Busy),
    .Done   (Done),
    .Hi     (Hi),
    .Lo     (Lo)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Edge k: present the request, then scramble the buses so late changes are exercised
  task automatic launch(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; busA = a; busB = b;
    tick();
    Start = 1'b0; Op = ~op; busA = ~a; busB = ~b;
    chk({tag, "_busy"}, {62'd0, Busy, Done}, {62'd0, 1'b1, 1'b0});
  endtask

  // Edges k+1..k+32 must be quiet with Hi/Lo held; edge k+33 delivers the result
  task automatic finish_op(input string tag, input logic [31:0] eh, input logic [31:0] el, input int poke);
    logic bad;
    bad = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      if (j == poke) begin
        Start = 1'b1; Op = 2'b00; busA = 32'd2; busB = 32'd3;
      end
      tick();
      Start = 1'b0;
      if (Done !== 1'b0 || Busy !== 1'b1 || Hi !== prev_hi || Lo !== prev_lo) bad = 1'b1;
    end
    chk({tag, "_calc"}, {63'd0, bad}, 64'd0);
    tick();
    chk({tag, "_done"}, {62'd0, Done, Busy}, {62'd0, 1'b1, 1'b0});
    chk({tag, "_hilo"}, {Hi, Lo}, {eh, el});
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    Resetn = 1'b0; Start = 1'b1; Op = 2'b00; busA = 32'd5; busB = 32'd5;
    prev_hi = '0; prev_lo = '0;
    // Reset wins over a simultaneous Start
    tick();
    tick();
    chk("reset_ctl", {62'd0, Busy, Done}, 64'd0);
    chk("reset_hilo", {Hi, Lo}, 64'd0);
    Start = 1'b0;
    Resetn = 1'b1;
    tick();
    chk("idle_ctl", {62'd0, Busy, Done}, 64'd0);

    launch("mulu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("mulu_max", 32'hFFFF_FFFE, 32'h0000_0001, 0);
    tick();
    chk("done_pulse", {63'd0, Done}, 64'd0);

    launch("mul_neg", 2'b01, 32'hFFFF_FFFD, 32'd7);
    finish_op("mul_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);

    // From here on each op starts on the previous op's Done cycle
    launch("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);

    launch("divu_zero", 2'b10, 32'd100, 32'd0);
    finish_op("divu_zero", 32'h0000_0064, 32'hFFFF_FFFF, 0);

    launch("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 32'h0000_0000, 32'h8000_0000, 0);

    launch("div_zero_s", 2'b11, 32'hFFFF_FFF9, 32'd0);
    finish_op("div_zero_s", 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);

    launch("mul_minint", 2'b01, 32'h8000_0000, 32'h8000_0000);
    finish_op("mul_minint", 32'h4000_0000, 32'h0000_0000, 0);

    launch("divu_7", 2'b10, 32'd100, 32'd7);
    finish_op("divu_7", 32'd2, 32'd14, 0);

    launch("div_rem_pos", 2'b11, 32'd7, 32'hFFFF_FFFE);
    finish_op("div_rem_pos", 32'd1, 32'hFFFF_FFFD, 0);

    // A Start at k+5 must not disturb the op in flight
    launch("busy_start", 2'b10, 32'd1000, 32'd7);
    finish_op("busy_start", 32'd6, 32'd142, 5);
    tick();
    chk("busy_start_idle", {62'd0, Busy, Done}, 64'd0);

    // Reset at CALC iteration 10 aborts the op; a new op starts on the first released edge
    launch("abort", 2'b00, 32'd123, 32'd456);
    for (int j = 1; j <= 9; j++) tick();
    Resetn = 1'b0;
    tick();
    chk("abort_ctl", {62'd0, Busy, Done}, 64'd0);
    chk("abort_hilo", {Hi, Lo}, 64'd0);
    Resetn = 1'b1;
    prev_hi = '0;
    prev_lo = '0;
    launch("mulu_small", 2'b00, 32'd6, 32'd7);
    finish_op("mulu_small", 32'd0, 32'd42, 0);
    tick();
    chk("final_idle", {62'd0, Busy, Done}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have one parameter: DATA_WIDTH, default 32, operand/result width (only 32 is required to work).
REQ-002 The block SHALL have port Clock, input, 1, rising-edge clock, shared with the register file.
REQ-003 The block SHALL have port Resetn, input, 1, reset (synchronous, active-low).
REQ-004 The block SHALL have port Start, input, 1, request pulse; accepted only when Busy=0.
REQ-005 The block SHALL have port Op, input, 2, 00 MULU, 01 MUL signed, 10 DIVU, 11 DIV signed.
REQ-006 The block SHALL have port busA, input, 32, operand A (multiplicand/dividend) from register-file read port A.
REQ-007 The block SHALL have port busB, input, 32, operand B (multiplier/divisor) from register-file read port B.
REQ-008 The block SHALL have port Busy, output, 1, operation in progress.
REQ-009 The block SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-010 The block SHALL have port Hi, output, 32, product high word / remainder.
REQ-011 The block SHALL have port Lo, output, 32, product low word / quotient.

Function
REQ-012 The block SHALL use states IDLE, CALC and FIX.
REQ-013 The block SHALL respect the start edge: Start=1 && Busy=0 at rising edge k captures Op, busA and busB (absolute values for signed ops, plus result-sign flags), enters CALC and sets Busy=1 from edge k.
REQ-014 The block SHALL run CALC for exactly 32 cycles (edges k+1..k+32), processing one bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-015 The block SHALL complete FIX at edge k+33: apply sign correction, load Hi/Lo, set Done=1, set Busy=0 and return to IDLE; the fixed latency is 33 cycles for every Op and every operand value.
REQ-016 The block SHALL drive Done high for exactly one cycle; Done is cleared at edge k+34 unless a new completion occurs then, which is impossible.
REQ-017 The block SHALL hold Hi/Lo stable from FIX until the next FIX; they do not change during CALC.
REQ-018 The block SHALL ignore Start while Busy=1, with no effect on the operation in flight.
REQ-019 The block SHALL accept Start in the same cycle Done=1 (Busy=0), i.e. back-to-back operations with no gap.
REQ-020 The block SHALL compute MULU as {Hi,Lo} = unsigned 64-bit product.
REQ-021 The block SHALL compute MUL as {Hi,Lo} = two's-complement 64-bit product.
REQ-022 The block SHALL compute DIVU as Lo = floor(A/B) and Hi = A mod B.
REQ-023 The block SHALL compute DIV as quotient truncated toward zero, with the remainder sign equal to the dividend sign.
REQ-024 The block SHALL handle divide by zero (both DIVU and DIV) as Lo=32'hFFFFFFFF and Hi=A unchanged, with the same 33-cycle latency and no error flag.
REQ-025 The block SHALL handle signed overflow (DIV 32'h80000000 / 32'hFFFFFFFF) as Lo=32'h80000000 and Hi=0.
REQ-026 The block SHALL handle the 32'h80000000 operand correctly in MUL and DIV; its absolute value is treated as unsigned 2^31.
REQ-027 The block SHALL treat operands as captured at edge k; changes on busA/busB/Op after edge k have no effect.

Reset
REQ-028 The block SHALL, when Resetn=0 at a rising edge, set the state to IDLE and set Busy=0, Done=0, Hi=0, Lo=0, and clear internal accumulators.
REQ-029 The block SHALL abort any operation in progress on reset mid-operation, with no Done pulse, and accept a new Start on the first edge with Resetn=1.
REQ-030 The block SHALL let Resetn take priority over Start at the same edge.

Verification
REQ-031 The bench SHALL cover MULU: A=32'hFFFFFFFF, B=32'hFFFFFFFF -> Hi=32'hFFFFFFFE, Lo=32'h00000001, Done at edge k+33 only.
REQ-032 The bench SHALL cover MUL: A=-3 (32'hFFFFFFFD), B=7 -> Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB.
REQ-033 The bench SHALL cover DIV: A=-7, B=2 -> Lo=32'hFFFFFFFD (-3), Hi=32'hFFFFFFFF (-1); then DIVU A=100, B=0 -> Lo=32'hFFFFFFFF, Hi=32'h00000064.
REQ-034 The bench SHALL cover DIV overflow: A=32'h80000000, B=32'hFFFFFFFF -> Lo=32'h80000000, Hi=0.
REQ-035 The bench SHALL cover Start during Busy and back-to-back: a second Start at k+5 is ignored (result belongs to the first op); a Start on the Done cycle launches the next op, which completes 33 cycles later.
REQ-036 The bench SHALL cover reset: Resetn=0 at CALC iteration 10 -> next cycle Busy=0, Done=0, Hi=Lo=0, no Done pulse afterwards; a following MULU 6*7 -> Lo=42, Hi=0.
